i2c_frame_timer: RTL and testbench
==================================

// Module: i2c_frame_timer
// PURPOSE
//  Parametrised SCL-edge frame timer for the I2C slave receive path. Counts SCL edges
//  inside a START..STOP window and emits one-cycle strobes for byte complete, ACK setup,
//  ACK sample and ACK end. Counts received bytes for key-block framing and flags stalled
//  transfers with an SCL inactivity timeout. Sits between the edge/start/stop detectors
//  and the receive controller FSM.
// PARAMETERS
//  DATA_BITS       8    data bits per frame (>=2); one ACK bit follows each frame
//  KEY_BYTES       16   bytes per key block (>=1); key_received strobes on the last one
//  TIMEOUT_CYCLES  0    clk cycles with no SCL edge before abort; 0 disables the timeout
// PORTS
//  clk                  in   1      system clock
//  n_rst                in   1      reset, asynchronous, active-low
//  rising_edge_found    in   1      SCL rising-edge strobe (1 cycle)
//  falling_edge_found   in   1      SCL falling-edge strobe (1 cycle)
//  start_found          in   1      START/repeated START detected (1 cycle)
//  stop_found           in   1      STOP detected (1 cycle)
//  start_byte_received  in   1      address byte accepted; clears byte_count
//  byte_received        out  1      strobe: last data bit sampled
//  ack_prep             out  1      strobe: drive ACK now (falling edge after last bit)
//  check_ack            out  1      strobe: ACK bit sampled (9th rising edge)
//  ack_done             out  1      strobe: ACK bit ended; release SDA
//  key_received         out  1      strobe: KEY_BYTES-th byte completed
//  bus_timeout          out  1      strobe: SCL inactivity abort
//  busy                 out  1      level: state != IDLE
//  byte_count           out  BW     bytes received in current key block, BW=$clog2(KEY_BYTES+1)
// BEHAVIOUR
//  Reset: state IDLE, edge/byte/timeout counters 0, every output 0.
//  Edge counter: EW=$clog2(2*DATA_BITS+2) bits, range 0..2*DATA_BITS+1.
//  edge = rising | falling; both asserted in the same cycle counts as ONE edge.
//  States:
//   IDLE: edges ignored. start_found -> ARM.
//   ARM (cnt=0): falling edges ignored; rising edge -> cnt=1, -> BIT.
//   BIT: every edge cnt++. Edge arriving while cnt==2*DATA_BITS+1 -> cnt=0, -> ARM.
//  Strobes are registered: high exactly 1 clk, in the cycle after the qualifying edge:
//   edge with cnt==2*DATA_BITS-2 (last data rising)   -> byte_received
//   edge with cnt==2*DATA_BITS-1 (last data falling)  -> ack_prep
//   edge with cnt==2*DATA_BITS   (ACK rising)         -> check_ack
//   edge with cnt==2*DATA_BITS+1 (ACK falling)        -> ack_done
//  Byte counter increments with each byte_received event; when it would reach KEY_BYTES,
//   key_received strobes in the same cycle as byte_received and byte_count wraps to 0.
//  start_byte_received: byte_count=0 next cycle; higher priority than increment.
//  start_found in any state: cnt=0, timeout cnt=0, -> ARM (repeated START); byte_count kept.
//  stop_found: -> IDLE, cnt=0, timeout cnt=0; byte_count kept. No strobe from that cycle's edge.
//  stop_found and start_found together: stop wins (IDLE).
//  start/stop win over any edge in the same cycle; that edge is not counted.
//  Timeout (TIMEOUT_CYCLES>0): in ARM/BIT a cycle counter clears on each counted edge and
//   on entering ARM, else increments. bus_timeout strobes exactly TIMEOUT_CYCLES clks after
//   the last counted edge/START; same cycle state -> IDLE, cnt=0, byte_count=0.
//   Inactive in IDLE. TIMEOUT_CYCLES=0: counter and bus_timeout tied off (output 0).
//  Async reset mid-frame: immediate return to reset values; no partial strobe afterwards.
// TESTING
//  T1 defaults: START, 9 SCL pulses -> byte_received 1 clk after 8th rise, ack_prep after
//     8th fall, check_ack after 9th rise, ack_done after 9th fall; each 1 clk wide; byte_count=1.
//  T2 START then falling edge before first rise -> ignored; next 9 pulses give T1 timing exactly.
//  T3 16 back-to-back bytes -> key_received coincident with 16th byte_received, byte_count=0;
//     start_byte_received after byte 5 -> byte_count=0, key needs 16 further bytes.
//  T4 STOP after 5th rising edge -> no strobes, busy=0; 20 more edges -> no strobes until START.
//  T5 TIMEOUT_CYCLES=100: stall after 3rd rise -> bus_timeout at clk 100 after that edge, busy=0;
//     stall of 99 clks then edge -> no timeout, frame completes normally.
//  T6 DATA_BITS=4, KEY_BYTES=2: byte_received after 4th rise, ack_done after 5th fall,
//     key_received on 2nd byte; simultaneous rise+fall counted once; n_rst mid-byte clears all.

Source files
------------

// File: rtl/i2c_frame_timer.sv
// SCL-edge frame timer for the I2C slave receive path: tracks bit/ACK phase
// inside a START..STOP window, counts bytes per key block and aborts stalled
// transfers after an SCL inactivity timeout.
module i2c_frame_timer #(
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned KEY_BYTES      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic                               clk,
  input  logic                               n_rst,
  input  logic                               rising_edge_found,
  input  logic                               falling_edge_found,
  input  logic                               start_found,
  input  logic                               stop_found,
  input  logic                               start_byte_received,
  output logic                               byte_received,
  output logic                               ack_prep,
  output logic                               check_ack,
  output logic                               ack_done,
  output logic                               key_received,
  output logic                               bus_timeout,
  output logic                               busy,
  output logic [$clog2(KEY_BYTES+1)-1:0]     byte_count
);

  localparam int unsigned EW = $clog2(2 * DATA_BITS + 2);
  localparam int unsigned BW = $clog2(KEY_BYTES + 1);
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [EW-1:0] CNT_BYTE = EW'(2 * DATA_BITS - 2);
  localparam logic [EW-1:0] CNT_PREP = EW'(2 * DATA_BITS - 1);
  localparam logic [EW-1:0] CNT_ACK  = EW'(2 * DATA_BITS);
  localparam logic [EW-1:0] CNT_LAST = EW'(2 * DATA_BITS + 1);
  localparam logic [BW-1:0] KEY_LAST = BW'(KEY_BYTES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_BIT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [EW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [BW-1:0]   byte_count_q, byte_count_d;
  logic            byte_received_q, byte_received_d;
  logic            ack_prep_q, ack_prep_d;
  logic            check_ack_q, check_ack_d;
  logic            ack_done_q, ack_done_d;
  logic            key_received_q, key_received_d;
  logic            bus_timeout_q, bus_timeout_d;
  logic            busy_q, busy_d;
  logic            counted;

  // State, counters and registered strobes
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      tcnt_q          <= '0;
      byte_count_q    <= '0;
      byte_received_q <= 1'b0;
      ack_prep_q      <= 1'b0;
      check_ack_q     <= 1'b0;
      ack_done_q      <= 1'b0;
      key_received_q  <= 1'b0;
      bus_timeout_q   <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      tcnt_q          <= tcnt_d;
      byte_count_q    <= byte_count_d;
      byte_received_q <= byte_received_d;
      ack_prep_q      <= ack_prep_d;
      check_ack_q     <= check_ack_d;
      ack_done_q      <= ack_done_d;
      key_received_q  <= key_received_d;
      bus_timeout_q   <= bus_timeout_d;
      busy_q          <= busy_d;
    end
  end

  // Next state: START/STOP override edges, then phase counting, timeout, byte count
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    tcnt_d          = tcnt_q;
    byte_count_d    = byte_count_q;
    byte_received_d = 1'b0;
    ack_prep_d      = 1'b0;
    check_ack_d     = 1'b0;
    ack_done_d      = 1'b0;
    key_received_d  = 1'b0;
    bus_timeout_d   = 1'b0;
    counted         = 1'b0;

    if (stop_found) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      tcnt_d  = '0;
    end else if (start_found) begin
      state_d = S_ARM;
      cnt_d   = '0;
      tcnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ARM: begin
          // A falling edge before the first rise is line settling, not a bit
          if (rising_edge_found) begin
            counted = 1'b1;
            cnt_d   = EW'(1);
            state_d = S_BIT;
          end
        end
        S_BIT: begin
          if (rising_edge_found || falling_edge_found) begin
            counted         = 1'b1;
            byte_received_d = (cnt_q == CNT_BYTE);
            ack_prep_d      = (cnt_q == CNT_PREP);
            check_ack_d     = (cnt_q == CNT_ACK);
            ack_done_d      = (cnt_q == CNT_LAST);
            if (cnt_q == CNT_LAST) begin
              cnt_d   = '0;
              state_d = S_ARM;
            end else begin
              cnt_d = cnt_q + EW'(1);
            end
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase

      if ((TIMEOUT_CYCLES != 0) && (state_q != S_IDLE)) begin
        if (counted) begin
          tcnt_d = '0;
        end else if (tcnt_q == TO_LAST) begin
          bus_timeout_d = 1'b1;
          state_d       = S_IDLE;
          cnt_d         = '0;
          tcnt_d        = '0;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
    end

    if (start_byte_received) begin
      byte_count_d = '0;
    end else if (byte_received_d) begin
      if (byte_count_q == KEY_LAST) begin
        byte_count_d   = '0;
        key_received_d = 1'b1;
      end else begin
        byte_count_d = byte_count_q + BW'(1);
      end
    end
    if (bus_timeout_d) begin
      byte_count_d = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  assign byte_received = byte_received_q;
  assign ack_prep      = ack_prep_q;
  assign check_ack     = check_ack_q;
  assign ack_done      = ack_done_q;
  assign key_received  = key_received_q;
  assign bus_timeout   = bus_timeout_q;
  assign busy          = busy_q;
  assign byte_count    = byte_count_q;

endmodule

// File: tb/tb_i2c_frame_timer.sv
// Bench for i2c_frame_timer: four parameterisations share one randomized and
// directed stimulus stream; each is compared every cycle with an edge-ordinal model.
module tb_i2c_frame_timer;

  localparam int NI = 4;
  localparam int P_D [NI] = '{8, 8, 4, 2};
  localparam int P_K [NI] = '{16, 16, 2, 1};
  localparam int P_T [NI] = '{0, 100, 0, 5};

  logic clk = 1'b0;
  logic n_rst;
  logic rise, fall, start, stop, sbr;

  logic [NI-1:0] o_br, o_ap, o_ca, o_ad, o_kr, o_to, o_busy;
  logic [4:0] bc0, bc1;
  logic [1:0] bc2;
  logic [0:0] bc3;

  int checks = 0;
  int failures = 0;

  // Model state: in_window, edges counted in current frame, bytes in block, idle cycles
  int m_win [NI], m_n [NI], m_bytes [NI], m_idle [NI];
  int e_br [NI], e_ap [NI], e_ca [NI], e_ad [NI], e_kr [NI], e_to [NI], e_busy [NI];

  always #5 clk = ~clk;

  i2c_frame_timer #(.DATA_BITS(8), .KEY_BYTES(16), .TIMEOUT_CYCLES(0)) u0 (
    .clk(clk), .n_rst(n_rst), .rising_edge_found(rise), .falling_edge_found(fall),
    .start_found(start), .stop_found(stop), .start_byte_received(sbr),
    .byte_received(o_br[0]), .ack_prep(o_ap[0]), .check_ack(o_ca[0]), .ack_done(o_ad[0]),
    .key_received(o_kr[0]), .bus_timeout(o_to[0]), .busy(o_busy[0]), .byte_count(bc0));
  i2c_frame_timer #(.DATA_BITS(8), .KEY_BYTES(16), .TIMEOUT_CYCLES(100)) u1 (
    .clk(clk), .n_rst(n_rst), .rising_edge_found(rise), .falling_edge_found(fall),
    .start_found(start), .stop_found(stop), .start_byte_received(sbr),
    .byte_received(o_br[1]), .ack_prep(o_ap[1]), .check_ack(o_ca[1]), .ack_done(o_ad[1]),
    .key_received(o_kr[1]), .bus_timeout(o_to[1]), .busy(o_busy[1]), .byte_count(bc1));
  i2c_frame_timer #(.DATA_BITS(4), .KEY_BYTES(2), .TIMEOUT_CYCLES(0)) u2 (
    .clk(clk), .n_rst(n_rst), .rising_edge_found(rise), .falling_edge_found(fall),
    .start_found(start), .stop_found(stop), .start_byte_received(sbr),
    .byte_received(o_br[2]), .ack_prep(o_ap[2]), .check_ack(o_ca[2]), .ack_done(o_ad[2]),
    .key_received(o_kr[2]), .bus_timeout(o_to[2]), .busy(o_busy[2]), .byte_count(bc2));
  i2c_frame_timer #(.DATA_BITS(2), .KEY_BYTES(1), .TIMEOUT_CYCLES(5)) u3 (
    .clk(clk), .n_rst(n_rst), .rising_edge_found(rise), .falling_edge_found(fall),
    .start_found(start), .stop_found(stop), .start_byte_received(sbr),
    .byte_received(o_br[3]), .ack_prep(o_ap[3]), .check_ack(o_ca[3]), .ack_done(o_ad[3]),
    .key_received(o_kr[3]), .bus_timeout(o_to[3]), .busy(o_busy[3]), .byte_count(bc3));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int dut_bc(input int i);
    case (i)
      0:       return int'(bc0);
      1:       return int'(bc1);
      2:       return int'(bc2);
      default: return int'(bc3);
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_win[i] = 0; m_n[i] = 0; m_bytes[i] = 0; m_idle[i] = 0;
      e_br[i] = 0; e_ap[i] = 0; e_ca[i] = 0; e_ad[i] = 0;
      e_kr[i] = 0; e_to[i] = 0; e_busy[i] = 0;
    end
  endtask

  // Frame rules in terms of edge ordinals: edge 2D-1 is the last data rise,
  // 2D the last data fall, 2D+1 the ACK rise, 2D+2 the ACK fall (frame end).
  task automatic model_step(input bit r, input bit f, input bit s, input bit p, input bit sb);
    bit cnt_edge;
    for (int i = 0; i < NI; i++) begin
      e_br[i] = 0; e_ap[i] = 0; e_ca[i] = 0; e_ad[i] = 0; e_kr[i] = 0; e_to[i] = 0;
      if (p) begin
        m_win[i] = 0; m_n[i] = 0; m_idle[i] = 0;
      end else if (s) begin
        m_win[i] = 1; m_n[i] = 0; m_idle[i] = 0;
      end else if (m_win[i] != 0) begin
        cnt_edge = (m_n[i] == 0) ? r : (r | f);
        if (cnt_edge) begin
          m_n[i]++;
          m_idle[i] = 0;
          if (m_n[i] == 2 * P_D[i] - 1) e_br[i] = 1;
          if (m_n[i] == 2 * P_D[i])     e_ap[i] = 1;
          if (m_n[i] == 2 * P_D[i] + 1) e_ca[i] = 1;
          if (m_n[i] == 2 * P_D[i] + 2) begin
            e_ad[i] = 1;
            m_n[i] = 0;
          end
        end else begin
          m_idle[i]++;
          if (P_T[i] != 0 && m_idle[i] == P_T[i]) begin
            e_to[i] = 1; m_win[i] = 0; m_n[i] = 0; m_idle[i] = 0;
          end
        end
      end
      if (sb) begin
        m_bytes[i] = 0;
      end else if (e_br[i] != 0) begin
        m_bytes[i]++;
        if (m_bytes[i] == P_K[i]) begin
          m_bytes[i] = 0;
          e_kr[i] = 1;
        end
      end
      if (e_to[i] != 0) m_bytes[i] = 0;
      e_busy[i] = m_win[i];
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("u%0d.byte_received", i), int'(o_br[i]), e_br[i]);
      chk($sformatf("u%0d.ack_prep", i), int'(o_ap[i]), e_ap[i]);
      chk($sformatf("u%0d.check_ack", i), int'(o_ca[i]), e_ca[i]);
      chk($sformatf("u%0d.ack_done", i), int'(o_ad[i]), e_ad[i]);
      chk($sformatf("u%0d.key_received", i), int'(o_kr[i]), e_kr[i]);
      chk($sformatf("u%0d.bus_timeout", i), int'(o_to[i]), e_to[i]);
      chk($sformatf("u%0d.busy", i), int'(o_busy[i]), e_busy[i]);
      chk($sformatf("u%0d.byte_count", i), dut_bc(i), m_bytes[i]);
    end
  endtask

  // One clock: check what the previous cycle produced, then apply new inputs
  task automatic tick(input bit r, input bit f, input bit s, input bit p, input bit sb);
    @(negedge clk);
    check_all();
    rise = r; fall = f; start = s; stop = p; sbr = sb;
    model_step(r, f, s, p, sb);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, 0, 0);
  endtask

  task automatic pulse(input int gap);
    tick(1, 0, 0, 0, 0);
    idle(gap);
    tick(0, 1, 0, 0, 0);
    idle(gap);
  endtask

  task automatic byte_frame();
    repeat (9) pulse(1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    rise = 0; fall = 0; start = 0; stop = 0; sbr = 0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  initial begin
    int dens;
    int dens_tab [6] = '{40, 15, 3, 60, 1, 25};
    n_rst = 1'b0;
    rise = 0; fall = 0; start = 0; stop = 0; sbr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy", int'(o_busy), 0);
    chk("reset.strobes", int'({o_br, o_ap, o_ca, o_ad, o_kr, o_to}), 0);
    chk("reset.byte_count", int'(bc0), 0);
    n_rst = 1'b1;

    // Basic frame
    tick(0, 0, 1, 0, 0);
    byte_frame();
    idle(2);
    chk("t1.byte_count", int'(bc0), 1);

    // Falling edge ahead of the first rise is ignored
    tick(0, 0, 1, 0, 0);
    tick(0, 1, 0, 0, 0);
    idle(1);
    byte_frame();
    idle(2);

    // Key block and address-byte clear
    tick(0, 0, 1, 0, 0);
    repeat (5) byte_frame();
    tick(0, 0, 0, 0, 1);
    repeat (17) byte_frame();
    idle(2);

    // STOP mid-byte, then edges outside a window
    tick(0, 0, 1, 0, 0);
    repeat (4) pulse(1);
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0);
    repeat (10) pulse(0);

    // Inactivity timeout and the just-in-time edge
    tick(0, 0, 1, 0, 0);
    repeat (2) pulse(1);
    tick(1, 0, 0, 0, 0);
    idle(110);
    tick(0, 0, 1, 0, 0);
    tick(1, 0, 0, 0, 0);
    idle(99);
    tick(0, 1, 0, 0, 0);
    repeat (8) pulse(1);
    tick(1, 0, 0, 0, 0);
    idle(98);
    tick(0, 1, 0, 0, 0);
    idle(3);

    // Simultaneous rise+fall, START+STOP collision, edge under START, reset mid-byte
    tick(0, 0, 1, 0, 0);
    tick(1, 1, 0, 0, 0);
    repeat (3) tick(1, 1, 0, 0, 0);
    tick(1, 0, 1, 1, 0);
    tick(1, 1, 1, 0, 0);
    repeat (5) pulse(1);
    do_reset();
    repeat (12) pulse(1);
    tick(0, 0, 1, 0, 0);
    repeat (5) pulse(0);
    do_reset();
    idle(3);

    // Randomized traffic at varying SCL activity
    for (int b = 0; b < 6; b++) begin
      dens = dens_tab[b];
      repeat (500) begin
        tick(($urandom % 100) < dens, ($urandom % 100) < dens,
             ($urandom % 200) < 2, ($urandom % 400) < 2, ($urandom % 100) < 1);
      end
    end
    idle(2);
    @(negedge clk);
    check_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
